apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  Converts a valid/ready command stream into APB3 transfers and returns one response per command.
//  Sits directly upstream of APB3 slaves: it drives the apb_if src modport (paddr/psel/penable/pwrite/pwdata).
//  It samples pready/prdata/pslverr. One transfer is outstanding at a time; command order is preserved.
// PARAMETERS
//  ADDR_W          32   paddr width; width of apb_if addr_t
//  DATA_W          32   pwdata/prdata width; width of apb_if data_t
//  TIMEOUT_CYCLES  256  ACCESS cycles without pready before abort (used only with APB_MASTER_BRIDGE_TIMEOUT_EN)
// PORTS
//  clk          in   1       clock; all logic on rising edge
//  rst_n        in   1       reset, asynchronous, active-low
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       bridge accepts command this cycle
//  cmd_addr     in   ADDR_W  target address
//  cmd_write    in   1       1 = write, 0 = read
//  cmd_wdata    in   DATA_W  write data; ignored for reads
//  rsp_valid    out  1       response present
//  rsp_ready    in   1       response consumed this cycle
//  rsp_rdata    out  DATA_W  read data; 0 for writes and aborted transfers
//  rsp_slverr   out  1       pslverr sampled at completion, or 1 on timeout
//  rsp_timeout  out  1       transfer aborted by timeout; tied 0 without the macro
//  apb          src  if      apb_if.src: paddr psel penable pwrite pwdata out; pready prdata pslverr in
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE.
//   - cmd_ready=0; rsp_valid=0; rsp_rdata=0; rsp_slverr=0; rsp_timeout=0.
//   - psel=0; penable=0; pwrite=0; paddr=0; pwdata=0.
//   - Reset mid-transfer abandons the transfer and drops psel immediately. No response is produced.
//  Handshake: a transfer occurs when valid&&ready is true at the clock edge.
//   - rsp_* holds stable while rsp_valid=1 && !rsp_ready.
//  cmd_ready = (state==IDLE) && (!rsp_valid || rsp_ready).
//   - cmd_ready is combinational from registered state and rsp_ready only; it never depends on cmd_valid.
//  FSM:
//   - IDLE -> SETUP when a command is accepted. In that edge, register paddr/pwrite/pwdata. pwdata is 0 for reads.
//   - SETUP: psel=1, penable=0. Unconditionally -> ACCESS.
//   - ACCESS: psel=1, penable=1. Stay while pready=0.
//   - On pready=1 -> IDLE. In that edge:
//       - set rsp_valid=1; rsp_slverr=pslverr; rsp_rdata = pwrite ? 0 : prdata.
//       - psel/penable drop to 0 in the next cycle.
//  Stability: paddr/pwrite/pwdata are constant from SETUP until the completing ACCESS edge.
//   - Between transfers they hold their last value; only psel/penable return to 0.
//  Latency: command accepted at edge N -> SETUP in cycle N+1 -> ACCESS in N+2.
//   - With pready=1 in N+2, rsp_valid=1 in N+3.
//   - Minimum 3 cycles per transfer; the next command can be accepted in N+3 if rsp_ready=1.
//  rsp_valid clears on rsp_ready unless a new response loads in the same edge.
//   - A new response cannot load in that edge, because completion needs ACCESS while rsp_valid was 0 at accept.
//  pslverr and prdata are sampled only when psel&&penable&&pready.
// CONFIGURATION
//  APB_MASTER_BRIDGE_TIMEOUT_EN defined:
//   - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
//   - After TIMEOUT_CYCLES such cycles the bridge goes to IDLE with psel=penable=0.
//   - It returns rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
//   - pready arriving in the same cycle as the limit wins as a normal completion.
//  Not defined: no counter; the bridge waits for pready indefinitely; rsp_timeout is constant 0.
// STRUCTURE
//  Package apb_master_bridge_pkg:
//   - state_e {IDLE,SETUP,ACCESS}.
//   - apb_cmd_t {addr,write,wdata}.
//   - apb_rsp_t {rdata,slverr,timeout}.
//   - localparam TIMEOUT_W = $clog2(TIMEOUT_CYCLES+1).
//  Single module; no sub-module. The FSM, timeout counter and response register are small enough to stay inline.
// TESTING
//  1. Write: cmd 0x0000_0010/0xDEAD_BEEF, pready=1 in ACCESS.
//     -> SETUP then ACCESS with pwrite=1, pwdata=0xDEADBEEF.
//     -> rsp_valid at N+3, rdata=0, slverr=0.
//  2. Read with wait states: cmd read 0x40, pready held 0 for 4 ACCESS cycles, then prdata=0x1234_5678.
//     -> penable high for 5 cycles; paddr stable.
//     -> rsp_rdata=0x12345678.
//  3. Error plus backpressure: pslverr=1 on completion, rsp_ready=0 for 3 cycles.
//     -> rsp held with slverr=1; cmd_ready=0 until rsp_ready.
//     -> a second command is accepted on the rsp_ready edge.
//  4. Back-to-back: 4 commands with cmd_valid always 1 and rsp_ready=1, pready=1.
//     -> one transfer per 3 cycles; responses in order; psel low exactly 1 cycle between transfers.
//  5. Reset mid-ACCESS: rst_n low while penable=1.
//     -> psel/penable/rsp_valid are 0 asynchronously; after release the next command proceeds normally.
//  6. Timeout (macro on, TIMEOUT_CYCLES=8): pready stuck 0.
//     -> after 8 ACCESS cycles: psel=0, rsp_slverr=1, rsp_timeout=1.
//     -> macro off: bridge still waits after 1000 cycles.

Source files
------------

// File: rtl/apb_master_bridge_pkg.sv
// Shared types for the valid/ready to APB3 master bridge.
// Defaults here match the bridge's default ADDR_W/DATA_W/TIMEOUT_CYCLES.
package apb_master_bridge_pkg;

    localparam int unsigned DEF_ADDR_W         = 32;
    localparam int unsigned DEF_DATA_W         = 32;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 256;
    localparam int unsigned TIMEOUT_W          = $clog2(DEF_TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_e;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic                  write;
        logic [DEF_DATA_W-1:0] wdata;
    } apb_cmd_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] rdata;
        logic                  slverr;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_if.sv
// APB3 bus bundle; src is the master side, dst the slave side.
interface apb_if
    import apb_master_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    addr_t paddr;
    logic  psel;
    logic  penable;
    logic  pwrite;
    data_t pwdata;
    logic  pready;
    data_t prdata;
    logic  pslverr;

    modport src (
        output paddr, psel, penable, pwrite, pwdata,
        input  pready, prdata, pslverr
    );

    modport dst (
        input  paddr, psel, penable, pwrite, pwdata,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/apb_master_bridge.sv
// Valid/ready command stream to APB3 master, one transfer outstanding.
// APB_MASTER_BRIDGE_TIMEOUT_EN adds an ACCESS-phase timeout abort.
module apb_master_bridge
    import apb_master_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_write,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_slverr,
    output logic              rsp_timeout,
    apb_if.src                apb
);

    state_e            state_q, state_d;
    logic              live_q;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_slverr_q, rsp_slverr_d;

`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_timeout_q, rsp_timeout_d;
`endif

    // live_q keeps cmd_ready low while reset is asserted
    assign cmd_ready = live_q && (state_q == IDLE)
                    && (!rsp_valid_q || rsp_ready);

    assign apb.psel    = (state_q != IDLE);
    assign apb.penable = (state_q == ACCESS);
    assign apb.paddr   = paddr_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.pwdata  = pwdata_q;

    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_slverr = rsp_slverr_q;
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        paddr_d      = paddr_q;
        pwrite_d     = pwrite_q;
        pwdata_d     = pwdata_q;
        rsp_valid_d  = rsp_valid_q && !rsp_ready;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_slverr_d = rsp_slverr_q;
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
        cnt_d         = cnt_q;
        rsp_timeout_d = rsp_timeout_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d  = SETUP;
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_write ? cmd_wdata : '0;
                end
            end
            SETUP: begin
                state_d = ACCESS;
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            ACCESS: begin
                // pready wins over a timeout hitting in the same cycle
                if (apb.pready) begin
                    state_d      = IDLE;
                    rsp_valid_d  = 1'b1;
                    rsp_slverr_d = apb.pslverr;
                    rsp_rdata_d  = pwrite_q ? '0 : apb.prdata;
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_slverr_d  = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            live_q       <= 1'b0;
            paddr_q      <= '0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b0;
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
            cnt_q         <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            live_q       <= 1'b1;
            paddr_q      <= paddr_d;
            pwrite_q     <= pwrite_d;
            pwdata_q     <= pwdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_slverr_q <= rsp_slverr_d;
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
            cnt_q         <= cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge with a behavioural APB slave.
// Timeout scenario depends on APB_MASTER_BRIDGE_TIMEOUT_EN.
module tb_apb_master_bridge;
    import apb_master_bridge_pkg::*;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;

    apb_if #(.ADDR_W(32), .DATA_W(32)) apb ();

    apb_master_bridge #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
        .rsp_timeout(rsp_timeout),
        .apb(apb)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // reference model: address map, error rule, memory
    apb_cmd_t    apb_q[$];
    apb_rsp_t    rsp_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];
    bit          stuck = 0;
    int          force_wait = -1;
    int          rr_mode = 1;

    function automatic logic is_err(input logic [31:0] a);
        return a[5:4] == 2'b11;
    endfunction

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'hC0DE_5A00;
    endfunction

    function automatic apb_rsp_t model(input apb_cmd_t c);
        apb_rsp_t r;
        r.rdata = '0;
        r.slverr = is_err(c.addr);
        r.timeout = 1'b0;
        if (stuck) begin
            r.slverr = 1'b1;
            r.timeout = 1'b1;
        end else if (c.write) begin
            if (!r.slverr) ref_mem[c.addr] = c.wdata;
        end else begin
            r.rdata = ref_mem.exists(c.addr) ? ref_mem[c.addr]
                                             : init_val(c.addr);
        end
        return r;
    endfunction

    // APB slave: random garbage when not completing
    int wl = 0;
    initial forever begin
        @(negedge clk);
        apb.pready = 1'b0;
        apb.prdata = $urandom;
        apb.pslverr = 1'($urandom);
        if (!rst_n) wl = 0;
        else if (apb.psel && !apb.penable)
            wl = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
        else if (apb.psel && apb.penable && !stuck) begin
            if (wl > 0) wl--;
            else begin
                apb.pready = 1'b1;
                apb.pslverr = is_err(apb.paddr);
                if (apb.pwrite) begin
                    if (!is_err(apb.paddr)) slv_mem[apb.paddr] = apb.pwdata;
                end else begin
                    apb.prdata = slv_mem.exists(apb.paddr)
                               ? slv_mem[apb.paddr] : init_val(apb.paddr);
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        rsp_ready = (rr_mode == 2) ? 1'($urandom) : (rr_mode == 1);
    end

    // APB-side monitor
    int gaps_q[$];
    int gap = 0;
    int acc_len = 0;
    int last_acc_len = 0;
    bit in_xfer = 0;
    apb_cmd_t cur;
    initial forever begin
        @(negedge clk); #1;
        if (!rst_n) begin
            in_xfer = 0;
            gap = 0;
        end else if (apb.psel && !apb.penable) begin
            gaps_q.push_back(gap);
            gap = 0;
            acc_len = 0;
            in_xfer = 1;
            if (apb_q.size() == 0) fail_now("apb_unexpected");
            else begin
                cur = apb_q.pop_front();
                check("apb_paddr", 64'(apb.paddr), 64'(cur.addr));
                check("apb_pwrite", 64'(apb.pwrite), 64'(cur.write));
                check("apb_pwdata", 64'(apb.pwdata), 64'(cur.wdata));
            end
        end else if (apb.psel && apb.penable) begin
            acc_len++;
            check("apb_stable", 64'({apb.paddr, apb.pwrite}),
                  64'({cur.addr, cur.write}));
        end else begin
            gap++;
            if (in_xfer) begin
                last_acc_len = acc_len;
                in_xfer = 0;
            end
        end
    end

    // response monitor / scoreboard
    int rise_cyc = 0;
    bit prev_v = 0;
    bit hold = 0;
    logic [33:0] held;
    apb_rsp_t exp_r;
    initial forever begin
        @(negedge clk); #1;
        if (!rst_n) begin
            hold = 0;
            prev_v = 0;
            continue;
        end
        if (rsp_valid && !prev_v) rise_cyc = cyc;
        if (hold)
            check("rsp_hold", 64'({rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout}),
                  64'({1'b1, held}));
        if (rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) fail_now("rsp_unexpected");
            else begin
                exp_r = rsp_q.pop_front();
                check("rsp_rdata", 64'(rsp_rdata), 64'(exp_r.rdata));
                check("rsp_slverr", 64'(rsp_slverr), 64'(exp_r.slverr));
                check("rsp_timeout", 64'(rsp_timeout), 64'(exp_r.timeout));
            end
        end
        hold = rsp_valid && !rsp_ready;
        held = {rsp_rdata, rsp_slverr, rsp_timeout};
        prev_v = rsp_valid;
    end

    task automatic send(input logic [31:0] a, input logic w,
                        input logic [31:0] d, output int acc_edge,
                        output int waited);
        apb_cmd_t c;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr = a;
        cmd_write = w;
        cmd_wdata = d;
        waited = 0;
        acc_edge = -1;
        #1;
        while (!cmd_ready && waited < 300) begin
            @(negedge clk); #1;
            waited++;
        end
        if (!cmd_ready) begin
            fail_now("cmd_accept");
            cmd_valid = 1'b0;
            return;
        end
        c.addr = a;
        c.write = w;
        c.wdata = w ? d : '0;
        apb_q.push_back(c);
        rsp_q.push_back(model(c));
        acc_edge = cyc + 1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_addr = $urandom;
        cmd_wdata = $urandom;
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while ((rsp_q.size() != 0 || apb_q.size() != 0) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk); #2;
        if (rsp_q.size() != 0 || apb_q.size() != 0) fail_now("drain");
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rsp_q.delete();
        apb_q.delete();
        stuck = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int e, w, n;
    int e4[4];
    initial begin
        #12;
        check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        check("rst_rsp_slverr", 64'(rsp_slverr), 64'(0));
        check("rst_rsp_timeout", 64'(rsp_timeout), 64'(0));
        check("rst_psel", 64'(apb.psel), 64'(0));
        check("rst_penable", 64'(apb.penable), 64'(0));
        check("rst_pwrite", 64'(apb.pwrite), 64'(0));
        check("rst_paddr", 64'(apb.paddr), 64'(0));
        check("rst_pwdata", 64'(apb.pwdata), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // single write, minimum latency
        force_wait = 0;
        send(32'h10, 1'b1, 32'hDEAD_BEEF, e, w);
        drain(50);
        check("t1_latency", 64'(rise_cyc - e), 64'(2));

        // read with 4 wait states
        ref_mem[32'h40] = 32'h1234_5678;
        slv_mem[32'h40] = 32'h1234_5678;
        force_wait = 4;
        send(32'h40, 1'b0, 32'h0, e, w);
        drain(50);
        check("t2_penable_cycles", 64'(last_acc_len), 64'(5));

        // slave error with response backpressure
        force_wait = 0;
        rr_mode = 0;
        send(32'h30, 1'b0, 32'h0, e, w);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        if (!rsp_valid) fail_now("t3_rsp_wait");
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(negedge clk); #1;
            end
            check("t3_cmd_ready_blocked", 64'(cmd_ready), 64'(0));
            check("t3_slverr", 64'(rsp_slverr), 64'(1));
        end
        rr_mode = 1;
        send(32'h44, 1'b1, 32'hA5A5_0001, e, w);
        check("t3_accept_on_rsp_ready", 64'(w), 64'(0));
        drain(50);

        // back-to-back
        gaps_q.delete();
        for (int i = 0; i < 4; i++)
            send({26'h0, 4'($urandom), 2'b00}, 1'($urandom), $urandom, e4[i], w);
        drain(50);
        for (int i = 1; i < 4; i++)
            check("t4_spacing", 64'(e4[i] - e4[i-1]), 64'(3));
        if (gaps_q.size() < 4) fail_now("t4_gap_count");
        else
            for (int i = 1; i < 4; i++)
                check("t4_psel_gap", 64'(gaps_q[i]), 64'(1));

        // reset in the middle of ACCESS
        stuck = 1;
        send(32'h08, 1'b0, 32'h0, e, w);
        n = 0;
        while (!apb.penable && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_psel", 64'(apb.psel), 64'(0));
        check("t5_penable", 64'(apb.penable), 64'(0));
        check("t5_rsp_valid", 64'(rsp_valid), 64'(0));
        rsp_q.delete();
        apb_q.delete();
        stuck = 0;
        @(negedge clk);
        rst_n = 1'b1;
        send(32'h0C, 1'b1, 32'h0BAD_F00D, e, w);
        send(32'h0C, 1'b0, 32'h0, e, w);
        drain(50);

`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
        stuck = 1;
        send(32'h04, 1'b0, 32'h0, e, w);
        drain(100);
        check("t6_access_len", 64'(last_acc_len), 64'(TMO));
        check("t6_psel_after", 64'(apb.psel), 64'(0));
        stuck = 0;
        force_wait = TMO - 1;
        send(32'h04, 1'b0, 32'h0, e, w);
        drain(100);
        check("t6_pready_at_limit", 64'(last_acc_len), 64'(TMO));
`else
        stuck = 1;
        send(32'h04, 1'b0, 32'h0, e, w);
        repeat (1000) @(negedge clk);
        #1;
        check("t6_still_psel", 64'(apb.psel), 64'(1));
        check("t6_still_penable", 64'(apb.penable), 64'(1));
        check("t6_no_rsp", 64'(rsp_valid), 64'(0));
        pulse_reset();
`endif

        // randomized traffic
        rr_mode = 2;
        force_wait = -1;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send({26'h0, 4'($urandom), 2'b00}, 1'($urandom), $urandom, e, w);
        end
        drain(5000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
